// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: framer states,
// parity modes and data-width select decode.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    function automatic logic [7:0] data_mask(input logic [1:0] sel);
        case (sel)
            DBITS_5: data_mask = 8'h1F;
            DBITS_6: data_mask = 8'h3F;
            DBITS_7: data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    endfunction

    // Index of the final data bit: 4..7 for 5..8 data bits.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] sel);
        last_bit_idx = {1'b0, sel} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Byte push handshake into the UART transmitter FIFO.
interface uart_tx_param_if;
    logic       Tx_Valid;
    logic [7:0] Tx_Parallel;
    logic       Tx_Accept;

    modport master (output Tx_Valid, output Tx_Parallel, input Tx_Accept);
    modport slave  (input Tx_Valid, input Tx_Parallel, output Tx_Accept);
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: small synchronous FIFO holding bytes queued for transmission.
// Latency: pushed data is visible at the head one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are dropped.
module uart_tx_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Purpose: UART transmitter with run-time data width, parity and stop bits.
// Latency: a byte pushed into an empty FIFO while idle starts its start bit one cycle later.
// Backpressure: Tx_Accept drops while the FIFO is full; frames go out back-to-back.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter  int BR_WIDTH   = 15,
    parameter  int FIFO_DEPTH = 4,
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_param_if.slave      tx,
    input  logic [BR_WIDTH-1:0] BR_Clocks,
    input  logic [1:0]          Data_Bits_Sel,
    input  logic [1:0]          Parity_Mode,
    input  logic                Stop_Bits,
    output logic                Tx_Serial,
    output logic                Tx_Complete,
    output logic                Tx_Idle,
    output logic [FIFO_AW:0]    Fifo_Count
);

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       pop;

    uart_tx_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx.Tx_Valid),
        .push_dat (tx.Tx_Parallel),
        .pop      (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (Fifo_Count)
    );

    assign tx.Tx_Accept = !fifo_full;

    tx_state_t           state;
    logic [BR_WIDTH-1:0] cnt;
    logic [BR_WIDTH-1:0] br_m1;
    logic [2:0]          bit_idx;
    logic [2:0]          last_idx;
    logic [7:0]          shreg;
    logic                par_en;
    logic                par_bit;
    logic                stop2;

    logic                bit_end;
    logic                stop_end;
    logic [7:0]          head_masked;
    logic                head_xor;

    assign bit_end     = (cnt == br_m1);
    assign stop_end    = (state == STOP) && bit_end && (!stop2 || bit_idx[0]);
    assign pop         = !fifo_empty && ((state == IDLE) || stop_end);
    assign head_masked = fifo_head & data_mask(Data_Bits_Sel);
    assign head_xor    = ^head_masked;
    assign Tx_Idle     = (state == IDLE) && fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            br_m1       <= '0;
            bit_idx     <= '0;
            last_idx    <= 3'd7;
            shreg       <= '0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            stop2       <= 1'b0;
            Tx_Serial   <= 1'b1;
            Tx_Complete <= 1'b0;
        end else begin
            Tx_Complete <= stop_end;
            if (pop) begin
                // Config is sampled only here, so mid-frame changes wait for the next byte.
                br_m1     <= (BR_Clocks == '0) ? '0 : BR_Clocks - 1'b1;
                last_idx  <= last_bit_idx(Data_Bits_Sel);
                shreg     <= head_masked;
                par_en    <= (Parity_Mode == PAR_EVEN) || (Parity_Mode == PAR_ODD);
                par_bit   <= (Parity_Mode == PAR_ODD) ? ~head_xor : head_xor;
                stop2     <= Stop_Bits;
                cnt       <= '0;
                bit_idx   <= '0;
                Tx_Serial <= 1'b0;
                state     <= START;
            end else begin
                case (state)
                    IDLE: begin
                        cnt       <= '0;
                        bit_idx   <= '0;
                        Tx_Serial <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            cnt       <= '0;
                            Tx_Serial <= shreg[0];
                            state     <= DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            cnt <= '0;
                            if (bit_idx == last_idx) begin
                                bit_idx <= '0;
                                if (par_en) begin
                                    Tx_Serial <= par_bit;
                                    state     <= PARITY;
                                end else begin
                                    Tx_Serial <= 1'b1;
                                    state     <= STOP;
                                end
                            end else begin
                                bit_idx   <= bit_idx + 1'b1;
                                shreg     <= shreg >> 1;
                                Tx_Serial <= shreg[1];
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            cnt       <= '0;
                            Tx_Serial <= 1'b1;
                            state     <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        Tx_Serial <= 1'b1;
                        if (bit_end) begin
                            cnt <= '0;
                            if (stop_end) begin
                                bit_idx <= '0;
                                state   <= IDLE;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        cnt       <= '0;
                        bit_idx   <= '0;
                        Tx_Serial <= 1'b1;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: hand-written serial bit strings per frame, checked every cycle.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int BRW = 15;
    localparam int FD  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [BRW-1:0] br;
    logic [1:0]     dsel;
    logic [1:0]     pmode;
    logic           stop2;
    logic           ser;
    logic           cmpl;
    logic           idle;
    logic [2:0]     fcnt;

    uart_tx_param_if txi();

    uart_tx_param #(
        .BR_WIDTH   (BRW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx            (txi),
        .BR_Clocks     (br),
        .Data_Bits_Sel (dsel),
        .Parity_Mode   (pmode),
        .Stop_Bits     (stop2),
        .Tx_Serial     (ser),
        .Tx_Complete   (cmpl),
        .Tx_Idle       (idle),
        .Fifo_Count    (fcnt)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] drv_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pushes every queued byte, honouring Tx_Accept; starts and ends on a negedge.
    task automatic drive();
        int   g;
        logic acc;
        while (drv_q.size() > 0) begin
            txi.Tx_Parallel = drv_q[0];
            txi.Tx_Valid    = 1'b1;
            g = 0;
            do begin
                acc = txi.Tx_Accept;
                @(negedge clk);
                g++;
            end while (!acc && g < 400);
            chk("push_acc", 32'(acc), 1);
            if (acc) void'(drv_q.pop_front());
            else drv_q.delete();
        end
        txi.Tx_Valid = 1'b0;
    endtask

    // Called on a negedge while idle; returns at the sample point of the frame's first cycle.
    task automatic start_tx();
        fork
            drive();
        join_none
        @(negedge clk);
        @(negedge clk);
    endtask

    // bits: line levels in transmission order, each held brc cycles.
    task automatic run_frame(input string tag, input string bits, input int brc);
        for (int i = 0; i < bits.len(); i++) begin
            for (int c = 0; c < brc; c++) begin
                chk(tag, 32'(ser), 32'(bits.getc(i) == "1"));
                if (i > 0 || c > 0) chk({tag, "_cmpl"}, 32'(cmpl), 0);
                chk({tag, "_idle"}, 32'(idle), 0);
                @(negedge clk);
            end
        end
        chk({tag, "_done"}, 32'(cmpl), 1);
    endtask

    initial begin
        logic saw_low;
        logic saw_cmpl;
        txi.Tx_Valid    = 1'b0;
        txi.Tx_Parallel = 8'h00;
        br    = 15'd4;
        dsel  = DBITS_8;
        pmode = PAR_NONE;
        stop2 = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("rst_ser", 32'(ser), 1);
        chk("rst_cmpl", 32'(cmpl), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_cnt", 32'(fcnt), 0);
        chk("rst_acc", 32'(txi.Tx_Accept), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 8N1, 4 cycles/bit, 0xA5
        drv_q = '{8'hA5};
        fork
            drive();
        join_none
        @(negedge clk);
        chk("t1_lat_ser", 32'(ser), 1);
        chk("t1_lat_cnt", 32'(fcnt), 1);
        chk("t1_lat_idle", 32'(idle), 0);
        @(negedge clk);
        chk("t1_pop_cnt", 32'(fcnt), 0);
        run_frame("t1", "0101001011", 4);
        chk("t1_idle", 32'(idle), 1);
        @(negedge clk);
        chk("t1_pulse", 32'(cmpl), 0);

        // 7E2 then 8O1, 3 cycles/bit, 0x41
        dsel = DBITS_7; pmode = PAR_EVEN; stop2 = 1'b1; br = 15'd3;
        drv_q = '{8'h41};
        start_tx();
        run_frame("t2e", "01000001011", 3);
        @(negedge clk);
        dsel = DBITS_8; pmode = PAR_ODD; stop2 = 1'b0;
        drv_q = '{8'h41};
        start_tx();
        run_frame("t2o", "01000001011", 3);
        @(negedge clk);

        // back-to-back 8N1, 2 cycles/bit
        pmode = PAR_NONE; br = 15'd2;
        drv_q = '{8'h00, 8'hFF, 8'h55};
        start_tx();
        chk("t3_cnt0", 32'(fcnt), 1);
        run_frame("t3a", "0000000001", 2);
        chk("t3_cnt1", 32'(fcnt), 1);
        run_frame("t3b", "0111111111", 2);
        chk("t3_cnt2", 32'(fcnt), 0);
        run_frame("t3c", "0101010101", 2);
        chk("t3_idle", 32'(idle), 1);
        @(negedge clk);

        // FIFO fill with Tx_Valid held high
        drv_q = '{8'h01, 8'h02, 8'h03, 8'h80, 8'hF0, 8'h0F};
        fork
            drive();
        join_none
        fork
            begin
                repeat (4) @(negedge clk);
                chk("t4_acc3", 32'(txi.Tx_Accept), 1);
                chk("t4_cnt3", 32'(fcnt), 3);
                @(negedge clk);
                chk("t4_acc4", 32'(txi.Tx_Accept), 0);
                chk("t4_cnt4", 32'(fcnt), 4);
            end
        join_none
        @(negedge clk);
        @(negedge clk);
        run_frame("t4_0", "0100000001", 2);
        chk("t4_cnt_r", 32'(fcnt), 3);
        chk("t4_acc_r", 32'(txi.Tx_Accept), 1);
        run_frame("t4_1", "0010000001", 2);
        run_frame("t4_2", "0110000001", 2);
        run_frame("t4_3", "0000000011", 2);
        run_frame("t4_4", "0000011111", 2);
        run_frame("t4_5", "0111100001", 2);
        chk("t4_cnt_e", 32'(fcnt), 0);
        chk("t4_idle", 32'(idle), 1);
        @(negedge clk);

        // width change mid-frame applies to the next frame only
        drv_q = '{8'hC3, 8'hFF};
        start_tx();
        fork
            begin
                repeat (5) @(negedge clk);
                dsel = DBITS_5;
            end
        join_none
        run_frame("t5a", "0110000111", 2);
        run_frame("t5b", "0111111", 2);
        @(negedge clk);
        dsel = DBITS_8;

        // divisor 0 behaves as 1
        br = 15'd0;
        drv_q = '{8'h3C};
        start_tx();
        run_frame("t6", "0001111001", 1);
        @(negedge clk);

        // reset in the middle of DATA abandons the frame and flushes the FIFO
        br = 15'd4;
        drv_q = '{8'hAA, 8'hBB};
        start_tx();
        repeat (5) @(negedge clk);
        chk("t7_pre_ser", 32'(ser), 0);
        chk("t7_pre_cnt", 32'(fcnt), 1);
        rst = 1'b1;
        #1;
        chk("t7_ser", 32'(ser), 1);
        chk("t7_cnt", 32'(fcnt), 0);
        chk("t7_idle", 32'(idle), 1);
        chk("t7_acc", 32'(txi.Tx_Accept), 1);
        @(negedge clk);
        chk("t7_cmpl", 32'(cmpl), 0);
        rst = 1'b0;
        saw_low  = 1'b0;
        saw_cmpl = 1'b0;
        repeat (60) begin
            @(negedge clk);
            saw_low  = saw_low | !ser;
            saw_cmpl = saw_cmpl | cmpl;
        end
        chk("t7_no_resume", 32'(saw_low), 0);
        chk("t7_no_pulse", 32'(saw_cmpl), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
